multicycle_step_sequencer: RTL and testbench
============================================

# multicycle_step_sequencer

Step sequencer for the multicycle RISC controller. It is the parametrised successor of the per-signal decode blocks. It owns the step counter `Cnt` and decodes each instruction class into a variable step count. It generates `Buff_PC`, `ALUorNot` and `IR_Load`, and adds stall, configurable memory wait states, halt/resume and illegal-opcode flagging. It sits between the instruction register and the datapath control decoders.

## Interface
- `CNT_W`, default 3: width of `Cnt`. Must satisfy 5 + `MEM_WAIT` ≤ 2^`CNT_W`.
- `MEM_WAIT`, default 0: extra execute cycles inserted into every load and store.
- `clk` input 1: single clock; all state changes on its rising edge.
- `Rst` input 1: reset. Asynchronous and active-low: `Rst`=0 immediately forces the reset state.
- `InsM` input [15:11]: opcode major field. Valid while `Cnt`==1.
- `InsL` input [1:0]: opcode minor field. Valid while `Cnt`==1.
- `Stall` input 1: freezes sequencing for the cycle.
- `Resume` input 1: leaves HALT.
- `Cnt` output `CNT_W`: current step; step 0 is fetch, step 1 is decode.
- `IR_Load` output 1: instruction register load strobe.
- `ALUorNot` output 1: ALU result selected for write-back.
- `Buff_PC` output 1: last step of the instruction; PC buffer update.
- `Halted` output 1: sequencer is in HALT.
- `Illegal` output 1: the decoded opcode is unknown (sticky per instruction).

## Operation
- States are RUN and HALT. A registered class `cls` is loaded at the end of the `Cnt`==1 cycle from `InsM`/`InsL`. Each class has a last step L, and `Buff_PC` = RUN & !`Stall` & (`Cnt`==L).
- Class table, giving (`InsM`, `InsL`) → class, L:
  - ALU class: 00000 with any `InsL`; 00110 with 01 (CMP); 00111 (ADDI); 01000 (SUBI); 01011 (MOV). L=3.
  - LHI/LLI: 00001, 00010. L=2.
  - LOAD: 00011, 00100. L=4+`MEM_WAIT`.
  - STORE: 00101; 00110 with `InsL`≠01. L=3+`MEM_WAIT`.
  - BRANCH: 11000, 11001. L=2.
  - JMP/JR: 10000, 10011. L=2.
  - JAL: 10001, 10010. L=3.
  - OUTR: 11100 with 00. L=2.
  - HLT: 11100 with 01. L=2.
  - All other codes: NOP, L=2, with `Illegal`=1 from `Cnt`==2 until the next `Cnt`==1 decode.
- Counter: in RUN with `Stall`=0, `Cnt` goes to 0 if `Buff_PC`, otherwise `Cnt`+1. Any `Stall`=1 holds `Cnt`, `cls` and state.
- `IR_Load` = RUN & !`Stall` & (`Cnt`==0).
- `ALUorNot` = RUN & !`Stall` & (`cls`==ALU) & (`Cnt`==2).
- HLT class: at `Cnt`==2, `Buff_PC` pulses and the state moves to HALT with `Cnt` set to 0.
- In HALT: `Halted`=1; `IR_Load`, `Buff_PC` and `ALUorNot` are 0; `Cnt` holds 0; `Stall` is ignored. `Resume`=1 returns to RUN, with `Cnt`=0 on the next cycle.
- Reset (any time, mid-instruction included): `Cnt`=0, `cls`=NOP, state RUN, `Halted`=0, `Illegal`=0. `IR_Load`=1 once `Rst` deasserts, provided `Stall`=0. All other outputs are 0.
- `Cnt` never exceeds L. When L is reached, the counter wraps to 0.

## Timing
- `Cnt`, `cls`, state and `Illegal` are registered. `IR_Load`, `ALUorNot` and `Buff_PC` are combinational from registered state and `Stall`, with no input-to-output path from `InsM`/`InsL`.
- Instruction latency in cycles is L+1 plus the number of stalled cycles. Example: ADD takes 4 cycles (`Cnt` 0,1,2,3), and `Buff_PC` is high in the `Cnt`==3 cycle.
- The decode sample is taken only on a non-stalled `Cnt`==1 cycle. A stall at `Cnt`==1 delays sampling, so `InsM`/`InsL` must be held for that time.
- `Stall` and `Buff_PC` in the same cycle: stall wins, so `Buff_PC`=0 and `Cnt` holds.
- `Resume` in the cycle HALT is entered is ignored; it is sampled only while `Halted`=1.

## Test plan
- Reset, then LHI (`InsM`=00001): `Cnt` sequence 0,1,2,0. `Buff_PC`=1 only at `Cnt`=2. `ALUorNot`=0 throughout.
- SUB (00000/10): `Cnt` sequence 0,1,2,3,0. `ALUorNot`=1 only at `Cnt`=2; `Buff_PC`=1 at `Cnt`=3.
- `MEM_WAIT`=2, LDRri (00011): `Buff_PC` at `Cnt`=6, for a total of 7 cycles. A 2-cycle `Stall` at `Cnt`=4 extends the total to 9 cycles, and `Buff_PC` stays 0 while stalled.
- HLT (11100/01): `Buff_PC` pulses at `Cnt`=2 and `Halted`=1 from the next cycle. Stall and 5 idle cycles leave `Cnt`=0 and `IR_Load`=0. `Resume`=1 gives `Halted`=0 and `IR_Load`=1 the following cycle.
- Unknown opcode 11111: `Illegal`=1 at `Cnt`=2 and `Buff_PC`=1 at `Cnt`=2. `Illegal` clears after the next decode of ADD.
- `Rst`=0 asserted asynchronously at `Cnt`=3 of a LOAD: `Cnt`=0 and all outputs 0 immediately, with no clock edge needed. After release, the LOAD is not resumed.

Source files
------------

// File: rtl/multicycle_step_sequencer.sv
// Step sequencer for the multicycle RISC controller: owns the step counter,
// decodes each instruction class into a last step and drives the step strobes.
module multicycle_step_sequencer #(
  parameter int CNT_W    = 3,
  parameter int MEM_WAIT = 0
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic [15:11]     InsM,
  input  logic [1:0]       InsL,
  input  logic             Stall,
  input  logic             Resume,
  output logic [CNT_W-1:0] Cnt,
  output logic             IR_Load,
  output logic             ALUorNot,
  output logic             Buff_PC,
  output logic             Halted,
  output logic             Illegal
);

  typedef enum logic [3:0] {
    CLS_ALU, CLS_LHI, CLS_LOAD, CLS_STORE, CLS_BRANCH,
    CLS_JMP, CLS_JAL, CLS_OUTR, CLS_HLT, CLS_NOP
  } cls_t;

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  localparam logic [CNT_W-1:0] L_SHORT = CNT_W'(2);
  localparam logic [CNT_W-1:0] L_ALU   = CNT_W'(3);
  localparam logic [CNT_W-1:0] L_LOAD  = CNT_W'(4 + MEM_WAIT);
  localparam logic [CNT_W-1:0] L_STORE = CNT_W'(3 + MEM_WAIT);

  state_t           state;
  cls_t             cls;
  cls_t             dec_cls;
  logic [CNT_W-1:0] last_step;
  logic             active;
  logic             at_last;

  // Opcode decode; only consumed on the non-stalled Cnt==1 cycle.
  always_comb begin
    dec_cls = CLS_NOP;
    case (InsM)
      5'b00000:                   dec_cls = CLS_ALU;
      5'b00001, 5'b00010:         dec_cls = CLS_LHI;
      5'b00011, 5'b00100:         dec_cls = CLS_LOAD;
      5'b00101:                   dec_cls = CLS_STORE;
      5'b00110:                   dec_cls = (InsL == 2'b01) ? CLS_ALU : CLS_STORE;
      5'b00111, 5'b01000, 5'b01011: dec_cls = CLS_ALU;
      5'b11000, 5'b11001:         dec_cls = CLS_BRANCH;
      5'b10000, 5'b10011:         dec_cls = CLS_JMP;
      5'b10001, 5'b10010:         dec_cls = CLS_JAL;
      5'b11100: begin
        if (InsL == 2'b00)      dec_cls = CLS_OUTR;
        else if (InsL == 2'b01) dec_cls = CLS_HLT;
        else                    dec_cls = CLS_NOP;
      end
      default:                    dec_cls = CLS_NOP;
    endcase
  end

  always_comb begin
    last_step = L_SHORT;
    case (cls)
      CLS_ALU, CLS_JAL: last_step = L_ALU;
      CLS_LOAD:         last_step = L_LOAD;
      CLS_STORE:        last_step = L_STORE;
      default:          last_step = L_SHORT;
    endcase
  end

  // Rst gates the strobes so they drop the instant reset asserts.
  assign active   = Rst & (state == ST_RUN) & ~Stall;
  assign at_last  = (Cnt == last_step);
  assign IR_Load  = active & (Cnt == '0);
  assign ALUorNot = active & (cls == CLS_ALU) & (Cnt == L_SHORT);
  assign Buff_PC  = active & at_last;
  assign Halted   = (state == ST_HALT);

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state   <= ST_RUN;
      Cnt     <= '0;
      cls     <= CLS_NOP;
      Illegal <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (!Stall) begin
            if (Cnt == CNT_W'(1)) begin
              cls     <= dec_cls;
              Illegal <= (dec_cls == CLS_NOP);
            end
            if (at_last) begin
              Cnt <= '0;
              if (cls == CLS_HLT) state <= ST_HALT;
            end else begin
              Cnt <= Cnt + CNT_W'(1);
            end
          end
        end
        ST_HALT: begin
          Cnt <= '0;
          if (Resume) state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_step_sequencer.sv
// Bench for multicycle_step_sequencer: directed literal checks plus random
// stimulus compared every cycle against an instruction-level reference model.
module tb_multicycle_step_sequencer;

  localparam int CNT_W    = 3;
  localparam int MEM_WAIT = 2;
  localparam int W        = CNT_W + 5;

  // Clock / reset block
  logic clk = 1'b0;
  logic Rst = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]       InsM;
  logic [1:0]       InsL;
  logic             Stall, Resume;
  logic [CNT_W-1:0] Cnt;
  logic             IR_Load, ALUorNot, Buff_PC, Halted, Illegal;

  multicycle_step_sequencer #(.CNT_W(CNT_W), .MEM_WAIT(MEM_WAIT)) dut (
    .clk(clk), .Rst(Rst), .InsM(InsM), .InsL(InsL), .Stall(Stall),
    .Resume(Resume), .Cnt(Cnt), .IR_Load(IR_Load), .ALUorNot(ALUorNot),
    .Buff_PC(Buff_PC), .Halted(Halted), .Illegal(Illegal)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: instruction-level view (halted flag, step, length, flags)
  bit m_halt = 1'b0;
  int m_step = 0;
  int m_len  = 2;
  bit m_alu  = 1'b0;
  bit m_hlt  = 1'b0;
  bit m_ill  = 1'b0;

  function automatic void ref_decode(input logic [4:0] m, input logic [1:0] l,
                                     output int len, output bit alu,
                                     output bit hlt, output bit ill);
    len = 2; alu = 1'b0; hlt = 1'b0; ill = 1'b0;
    if (m == 0 || (m == 6 && l == 1) || m == 7 || m == 8 || m == 11) begin
      len = 3; alu = 1'b1;
    end else if (m == 1 || m == 2 || m == 24 || m == 25 || m == 16 || m == 19 ||
                 (m == 28 && l == 0)) begin
      len = 2;
    end else if (m == 3 || m == 4) begin
      len = 4 + MEM_WAIT;
    end else if (m == 5 || m == 6) begin
      len = 3 + MEM_WAIT;
    end else if (m == 17 || m == 18) begin
      len = 3;
    end else if (m == 28 && l == 1) begin
      hlt = 1'b1;
    end else begin
      ill = 1'b1;
    end
  endfunction

  function automatic logic [W-1:0] dut_vec();
    return {Cnt, IR_Load, ALUorNot, Buff_PC, Halted, Illegal};
  endfunction

  task automatic check_vec(input string name, input logic [W-1:0] exp);
    logic [W-1:0] act;
    act = dut_vec();
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got {cnt,ir,alu,bpc,halt,ill}=%b want %b at %0t",
               name, act, exp, $time);
    end
  endtask

  // Scoreboard: model expectation each cycle, compared on the falling edge
  always @(negedge clk) begin : mdl
    logic [W-1:0] e;
    bit act;
    if (!Rst) begin
      m_halt = 1'b0; m_step = 0; m_len = 2;
      m_alu = 1'b0; m_hlt = 1'b0; m_ill = 1'b0;
      e = '0;
    end else if (m_halt) begin
      e = {CNT_W'(0), 1'b0, 1'b0, 1'b0, 1'b1, m_ill};
      if (Resume) begin
        m_halt = 1'b0;
        m_step = 0;
      end
    end else begin
      act = !Stall;
      e = {CNT_W'(m_step), act && m_step == 0, act && m_alu && m_step == 2,
           act && m_step == m_len, 1'b0, m_ill};
      if (act) begin
        if (m_step == 1) ref_decode(InsM, InsL, m_len, m_alu, m_hlt, m_ill);
        if (m_step == m_len) begin
          m_step = 0;
          if (m_hlt) m_halt = 1'b1;
        end else begin
          m_step++;
        end
      end
    end
    exp_q.push_back(e);
    check_vec("cycle", exp_q.pop_front());
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int c, input bit ir, input bit alu,
                     input bit bpc, input bit h, input bit il);
    #1;
    check_vec(name, {CNT_W'(c), ir, alu, bpc, h, il});
  endtask

  task automatic run_ldr_stalled();
    InsM = 5'b00011; InsL = 2'b00;
    for (int k = 0; k <= 3; k++) begin
      chk("ldrs_step", k, k == 0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    Stall = 1'b1;
    chk("ldrs_stall1", 4, 0, 0, 0, 0, 0);
    tick();
    chk("ldrs_stall2", 4, 0, 0, 0, 0, 0);
    tick();
    Stall = 1'b0;
    for (int k = 4; k <= 6; k++) begin
      chk("ldrs_tail", k, 1'b0, 1'b0, k == 6, 1'b0, 1'b0);
      tick();
    end
    chk("ldrs_wrap", 0, 1, 0, 0, 0, 0);
  endtask

  int ops[17] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 11, 16, 17, 18, 19, 24, 25, 28};

  initial begin
    InsM = 5'b0; InsL = 2'b0; Stall = 1'b0; Resume = 1'b0;
    repeat (2) tick();
    chk("reset_state", 0, 0, 0, 0, 0, 0);
    Rst = 1'b1;
    chk("reset_release", 0, 1, 0, 0, 0, 0);

    // LHI: 0,1,2,0 with Buff_PC at step 2
    InsM = 5'b00001;
    tick(); chk("lhi_c1", 1, 0, 0, 0, 0, 0);
    tick(); chk("lhi_c2", 2, 0, 0, 1, 0, 0);
    tick(); chk("lhi_wrap", 0, 1, 0, 0, 0, 0);

    // SUB: ALUorNot at step 2, Buff_PC at step 3
    InsM = 5'b00000; InsL = 2'b10;
    tick(); chk("sub_c1", 1, 0, 0, 0, 0, 0);
    tick(); chk("sub_c2", 2, 0, 1, 0, 0, 0);
    tick(); chk("sub_c3", 3, 0, 0, 1, 0, 0);
    tick(); chk("sub_wrap", 0, 1, 0, 0, 0, 0);

    // LDRri unstalled: 7 cycles, Buff_PC at step 6
    InsM = 5'b00011; InsL = 2'b00;
    for (int k = 0; k <= 6; k++) begin
      chk("ldr_step", k, k == 0, 1'b0, k == 6, 1'b0, 1'b0);
      tick();
    end
    run_ldr_stalled();

    // HLT, with a Resume in the entry cycle that must be ignored
    InsM = 5'b11100; InsL = 2'b01;
    tick(); chk("hlt_c1", 1, 0, 0, 0, 0, 0);
    tick(); Resume = 1'b1;
    chk("hlt_c2", 2, 0, 0, 1, 0, 0);
    tick(); Resume = 1'b0;
    chk("hlt_enter", 0, 0, 0, 0, 1, 0);
    Stall = 1'b1;
    repeat (5) begin
      tick(); chk("halt_idle", 0, 0, 0, 0, 1, 0);
    end
    Stall = 1'b0; Resume = 1'b1;
    tick(); Resume = 1'b0;
    chk("resume", 0, 1, 0, 0, 0, 0);

    // Unknown opcode then ADD clears Illegal
    InsM = 5'b11111; InsL = 2'b00;
    tick(); chk("ill_c1", 1, 0, 0, 0, 0, 0);
    tick(); chk("ill_c2", 2, 0, 0, 1, 0, 1);
    tick(); chk("ill_wrap", 0, 1, 0, 0, 0, 1);
    InsM = 5'b00000;
    tick(); chk("ill_hold", 1, 0, 0, 0, 0, 1);
    tick(); chk("ill_clear", 2, 0, 1, 0, 0, 0);
    tick(); chk("add_c3", 3, 0, 0, 1, 0, 0);
    tick();

    // Asynchronous reset at step 3 of a LOAD
    InsM = 5'b00011;
    tick(); tick(); tick();
    chk("load_c3", 3, 0, 0, 0, 0, 0);
    Rst = 1'b0;
    chk("async_rst", 0, 0, 0, 0, 0, 0);
    tick();
    Rst = 1'b1;
    chk("post_rst", 0, 1, 0, 0, 0, 0);
    InsM = 5'b00001;
    tick(); chk("no_resume", 1, 0, 0, 0, 0, 0);

    // Random stimulus, checked by the scoreboard every cycle
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(0, 3) == 0) InsM = 5'($urandom_range(0, 31));
      else                           InsM = 5'(ops[$urandom_range(0, 16)]);
      InsL   = 2'($urandom_range(0, 3));
      Stall  = ($urandom_range(0, 4) == 0);
      Resume = ($urandom_range(0, 3) == 0);
      Rst    = ($urandom_range(0, 149) != 0);
    end
    Rst = 1'b1; Stall = 1'b0; Resume = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
